// File: rtl/prewish_mentor.sv
// Upstream controller for prewish_blinky: cycles a 4-entry LED mask table into the blinky
// with a one-cycle load strobe. A debounced button forces an advance; pause freezes the dwell timer.
module prewish_mentor #(
  parameter logic [23:0] DWELL_CYCLES    = 24'd12_000_000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd60_000,
  parameter logic [7:0]  PATTERN0        = 8'b10100000,
  parameter logic [7:0]  PATTERN1        = 8'b11110000,
  parameter logic [7:0]  PATTERN2        = 8'b10101010,
  parameter logic [7:0]  PATTERN3        = 8'b11001100
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       i_button,
  input  logic       i_pause,
  output logic       RST_O,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic [1:0] o_pattern_idx
);

  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam int DB_W = (DEBOUNCE_CYCLES > 16'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 24'd1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 16'd1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_DWELL   = 2'd2,
    ST_ADVANCE = 2'd3
  } state_t;

  function automatic logic [7:0] pattern_of(input logic [1:0] idx);
    logic [7:0] pat;
    case (idx)
      2'd0:    pat = PATTERN0;
      2'd1:    pat = PATTERN1;
      2'd2:    pat = PATTERN2;
      2'd3:    pat = PATTERN3;
      default: pat = PATTERN0;
    endcase
    return pat;
  endfunction

  logic            r_sync1;
  logic            r_sync2;
  logic            r_db_level;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;

  state_t          r_state;
  logic            r_init_seen;
  logic            r_pending;
  logic [DW_W-1:0] r_dwell_cnt;
  logic [1:0]      r_idx;
  logic            r_rst;
  logic            r_stb;
  logic [7:0]      r_dat;

  logic [1:0]      w_next_idx;
  logic            w_expire;

  assign w_next_idx = r_idx + 2'd1;
  assign w_expire   = !i_pause && (r_dwell_cnt == DWELL_LAST);

  // Button synchroniser and debouncer; r_press pulses once per accepted 0->1 change.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= {DB_W{1'b0}};
      r_press    <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_db_level) begin
        if (r_db_cnt == DB_LAST) begin
          r_db_level <= r_sync2;
          r_db_cnt   <= {DB_W{1'b0}};
          r_press    <= r_sync2;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
          r_press  <= 1'b0;
        end
      end else begin
        r_db_cnt <= {DB_W{1'b0}};
        r_press  <= 1'b0;
      end
    end
  end

  // Sequencer; outputs are updated on entry to the state that owns them.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state     <= ST_INIT;
      r_init_seen <= 1'b0;
      r_pending   <= 1'b0;
      r_dwell_cnt <= {DW_W{1'b0}};
      r_idx       <= 2'd0;
      r_rst       <= 1'b1;
      r_stb       <= 1'b0;
      r_dat       <= 8'd0;
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (r_press) begin
            r_pending <= 1'b1;
          end else begin
            r_pending <= r_pending;
          end
          // The first edge after release only marks INIT as seen, so RST_O spans a full clock.
          if (r_init_seen) begin
            r_state <= ST_LOAD;
            r_rst   <= 1'b0;
            r_stb   <= 1'b1;
            r_dat   <= pattern_of(r_idx);
          end else begin
            r_init_seen <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state     <= ST_DWELL;
          r_dwell_cnt <= {DW_W{1'b0}};
          if (r_press) begin
            r_pending <= 1'b1;
          end else begin
            r_pending <= r_pending;
          end
        end
        ST_DWELL: begin
          if (r_press || r_pending || w_expire) begin
            r_state   <= ST_ADVANCE;
            r_pending <= 1'b0;
          end else if (!i_pause) begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
          end else begin
            r_dwell_cnt <= r_dwell_cnt;
          end
        end
        ST_ADVANCE: begin
          r_state   <= ST_LOAD;
          r_idx     <= w_next_idx;
          r_dat     <= pattern_of(w_next_idx);
          r_stb     <= 1'b1;
          r_pending <= r_press;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign RST_O         = r_rst;
  assign STB_O         = r_stb;
  assign DAT_O         = r_dat;
  assign o_pattern_idx = r_idx;

endmodule
